shared_dmem_ctrl: RTL and testbench

SHARED_DMEM_CTRL -- requirements
Module: shared_dmem_ctrl

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/shared_dmem_ctrl.sv | 152 +++++++++++++++
 tb/tb_shared_dmem_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the shared data-memory controller: default sizes,
// the access-kind encoding and the address range helper.
package dmem_pkg;

    localparam int NPORT_DEF = 8;   // CPU request ports
    localparam int AW_DEF    = 6;   // word-address width (64 words)
    localparam int DW        = 32;  // data width

    // Kind of memory access performed at the end of the current cycle
    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } acc_e;

    // A byte address is in range when every bit above the word index is zero
    function automatic logic addr_in_range(input logic [31:0] a, input int unsigned aw);
        return ((a >> (aw + 2)) == 32'd0);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requesting port starting at i_ptr,
// wrapping from NPORT-1 back to 0. Purely combinational.
module rr_arbiter #(
    parameter int NPORT = dmem_pkg::NPORT_DEF,
    parameter int PW    = (NPORT > 1) ? $clog2(NPORT) : 1
) (
    input  logic [NPORT-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic [NPORT-1:0] o_gnt,
    output logic [PW-1:0]    o_idx,
    output logic             o_valid
);

    // Scan ports in priority order ptr, ptr+1, ... and take the first requester
    always_comb begin
        logic [PW:0]   w_sum;
        logic [PW-1:0] w_j;
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_sum   = '0;
        w_j     = '0;
        for (int k = 0; k < NPORT; k++) begin
            w_sum = {1'b0, i_ptr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(NPORT)) begin
                w_sum = w_sum - (PW+1)'(NPORT);
            end
            w_j = w_sum[PW-1:0];
            if (!o_valid && i_req[w_j]) begin
                o_valid    = 1'b1;
                o_idx      = w_j;
                o_gnt[w_j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_dmem_ctrl.sv
// Shared data memory for NPORT CPU ports: one access per cycle chosen by a
// round-robin arbiter, per-port registered read data, and activity counters.
module shared_dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int NPORT = NPORT_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NPORT-1:0]    req,
    input  logic [NPORT-1:0]    we,
    input  logic [NPORT*DW-1:0] addr,
    input  logic [NPORT*DW-1:0] wdata,
    output logic [NPORT-1:0]    gnt,
    output logic [NPORT-1:0]    rvalid,
    output logic [NPORT*DW-1:0] rdata,
    output logic [31:0]         busy_cnt,
    output logic [31:0]         stall_cnt
);

    localparam int PW    = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int CW    = $clog2(NPORT + 1);
    localparam int DEPTH = 1 << AW;

    logic [PW-1:0]       r_ptr;
    logic [NPORT-1:0]    r_rvalid;
    logic [NPORT*DW-1:0] r_rdata;
    logic [31:0]         r_busy;
    logic [31:0]         r_stall;
    logic [DW-1:0]       r_mem [DEPTH];

    logic [NPORT-1:0]    w_arb_gnt;
    logic [PW-1:0]       w_idx;
    logic                w_arb_valid;
    logic                w_grant_ok;
    logic [DW-1:0]       w_sel_addr;
    logic [DW-1:0]       w_sel_wdata;
    logic                w_sel_we;
    logic                w_in_range;
    logic [AW-1:0]       w_word;
    logic [DW-1:0]       w_rd_word;
    logic [CW-1:0]       w_popcnt;
    acc_e                w_acc;

    rr_arbiter #(
        .NPORT (NPORT),
        .PW    (PW)
    ) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_arb_gnt),
        .o_idx   (w_idx),
        .o_valid (w_arb_valid)
    );

    // Nothing is granted while reset is held
    assign w_grant_ok = w_arb_valid & ~reset;
    assign gnt        = reset ? '0 : w_arb_gnt;

    // Route the granted port's address, data and direction to the memory
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            if (w_arb_gnt[i]) begin
                w_sel_addr  = addr[i*DW +: DW];
                w_sel_wdata = wdata[i*DW +: DW];
                w_sel_we    = we[i];
            end
        end
    end

    // Decode the access; addr[1:0] is ignored, high bits flag out-of-range
    always_comb begin
        w_word     = w_sel_addr[AW+1:2];
        w_in_range = addr_in_range(w_sel_addr, AW);
        if (!w_grant_ok) begin
            w_acc = ACC_NONE;
        end else if (w_sel_we) begin
            w_acc = ACC_WRITE;
        end else begin
            w_acc = ACC_READ;
        end
        w_rd_word = w_in_range ? r_mem[w_word] : '0;
    end

    // Number of ports requesting this cycle
    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < NPORT; i++) begin
            w_popcnt = w_popcnt + CW'(req[i]);
        end
    end

    // Storage array: synchronous write, contents survive reset
    always_ff @(posedge clk) begin
        if (w_acc == ACC_WRITE && w_in_range) begin
            r_mem[w_word] <= w_sel_wdata;
        end
    end

    // Capture read data into the granted port's register and pulse its rvalid
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= '0;
            if (w_acc == ACC_READ) begin
                r_rvalid <= w_arb_gnt;
                for (int i = 0; i < NPORT; i++) begin
                    if (w_arb_gnt[i]) begin
                        r_rdata[i*DW +: DW] <= w_rd_word;
                    end
                end
            end
        end
    end

    // Advance the round-robin pointer past the port just served
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_grant_ok) begin
            if (w_idx == PW'(NPORT - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_idx + PW'(1);
            end
        end
    end

    // Busy and stall counters, free-running with natural 32-bit wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy  <= '0;
            r_stall <= '0;
        end else if (req != '0) begin
            r_busy  <= r_busy + 32'd1;
            r_stall <= r_stall + 32'(w_popcnt) - 32'd1;
        end
    end

    // A read pending from the cycle before reset must not surface during reset
    assign rvalid    = reset ? '0 : r_rvalid;
    assign rdata     = reset ? '0 : r_rdata;
    assign busy_cnt  = r_busy;
    assign stall_cnt = r_stall;

endmodule

// File: tb/tb_shared_dmem_ctrl.sv
// Bench for shared_dmem_ctrl: directed scenarios plus randomized traffic,
// all checked against a transaction-level memory/arbitration model.
module tb_shared_dmem_ctrl;

    localparam int NP  = 8;
    localparam int AWT = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic [NP-1:0] req, we;
    logic [NP*32-1:0] addr, wdata;
    logic [NP-1:0] gnt, rvalid;
    logic [NP*32-1:0] rdata;
    logic [31:0]   busy_cnt, stall_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0]      m_mem [64];
    int               m_ptr;
    logic [31:0]      m_busy, m_stall;
    logic [NP*32-1:0] m_rdata;
    logic [NP-1:0]    m_rvalid;

    // expected / observed outputs for the most recent cycle
    logic [NP-1:0]    exp_gnt, exp_rvalid, obs_gnt, obs_rvalid;
    logic [NP*32-1:0] exp_rdata, obs_rdata;
    logic [31:0]      exp_busy, exp_stall, obs_busy, obs_stall;

    shared_dmem_ctrl #(.NPORT(NP), .AW(AWT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .busy_cnt  (busy_cnt),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int rr_pick(input logic [NP-1:0] r, input int p);
        for (int k = 0; k < NP; k++) begin
            if (r[(p + k) % NP]) return (p + k) % NP;
        end
        return -1;
    endfunction

    // Drive one cycle, sample outputs mid-cycle, then advance the model at the edge
    task automatic step(input logic rst, input logic [NP-1:0] rq, input logic [NP-1:0] w,
                        input logic [NP*32-1:0] a, input logic [NP*32-1:0] d);
        int pick;
        logic [31:0] a32;
        reset = rst; req = rq; we = w; addr = a; wdata = d;
        pick       = rst ? -1 : rr_pick(rq, m_ptr);
        exp_gnt    = (pick >= 0) ? (NP'(1) << pick) : '0;
        exp_rvalid = rst ? '0 : m_rvalid;
        exp_rdata  = rst ? '0 : m_rdata;
        exp_busy   = m_busy;
        exp_stall  = m_stall;
        @(negedge clk);
        obs_gnt = gnt; obs_rvalid = rvalid; obs_rdata = rdata;
        obs_busy = busy_cnt; obs_stall = stall_cnt;
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_busy = '0; m_stall = '0; m_rdata = '0; m_rvalid = '0;
        end else begin
            m_rvalid = '0;
            if (rq != '0) begin
                m_busy  = m_busy + 32'd1;
                m_stall = m_stall + 32'($countones(rq) - 1);
            end
            if (pick >= 0) begin
                a32 = a[pick*32 +: 32];
                if (w[pick]) begin
                    if ((a32 >> (AWT + 2)) == 0) m_mem[a32[7:2]] = d[pick*32 +: 32];
                end else begin
                    m_rdata[pick*32 +: 32] = ((a32 >> (AWT + 2)) == 0) ? m_mem[a32[7:2]] : 32'h0;
                    m_rvalid[pick] = 1'b1;
                end
                m_ptr = (pick + 1) % NP;
            end
        end
        #1;
    endtask

    task automatic one(input int p, input logic wr, input logic [31:0] ad, input logic [31:0] dt);
        logic [NP*32-1:0] a, d;
        logic [NP-1:0] rq, w;
        a = '0; d = '0; rq = '0; w = '0;
        a[p*32 +: 32] = ad; d[p*32 +: 32] = dt; rq[p] = 1'b1; w[p] = wr;
        step(1'b0, rq, w, a, d);
    endtask

    task automatic idle();
        step(1'b0, '0, '0, '0, '0);
    endtask

    task automatic test_reset();
        step(1'b1, '0, '0, '0, '0);
        step(1'b1, 8'hFF, 8'hFF, '0, '0);
        checks++;
        if (obs_gnt !== 8'h00) begin errors++; $display("FAIL reset_gnt: got %h expected 00", obs_gnt); end
        checks++;
        if (obs_rvalid !== 8'h00) begin errors++; $display("FAIL reset_rvalid: got %h expected 00", obs_rvalid); end
        idle();
        checks++;
        if (obs_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", obs_rdata); end
        checks++;
        if (obs_busy !== 32'd0 || obs_stall !== 32'd0) begin
            errors++; $display("FAIL reset_counters: got busy %0d stall %0d expected 0 0", obs_busy, obs_stall);
        end
    endtask

    task automatic init_mem();
        int bad = 0;
        for (int i = 0; i < 64; i++) begin
            one(0, 1'b1, 32'(i * 4), $urandom);
            if (obs_gnt !== 8'h01) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL init_gnt: got %0d bad grants expected 0", bad); end
        idle();
    endtask

    task automatic test_single_write();
        one(0, 1'b1, 32'h10, 32'hDEADBEEF);
        checks++;
        if (obs_gnt !== 8'h01) begin errors++; $display("FAIL sw_gnt_wr: got %h expected 01", obs_gnt); end
        one(0, 1'b0, 32'h10, 32'h0);
        checks++;
        if (obs_gnt !== 8'h01) begin errors++; $display("FAIL sw_gnt_rd: got %h expected 01", obs_gnt); end
        idle();
        checks++;
        if (obs_rvalid !== 8'h01) begin errors++; $display("FAIL sw_rvalid: got %h expected 01", obs_rvalid); end
        checks++;
        if (obs_rdata[31:0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL sw_rdata: got %h expected deadbeef", obs_rdata[31:0]);
        end
    endtask

    task automatic test_contention();
        step(1'b1, '0, '0, '0, '0);
        for (int k = 0; k < NP; k++) begin
            step(1'b0, 8'hFF << k, '0, '0, '0);
            checks++;
            if (obs_gnt !== (8'h01 << k)) begin
                errors++; $display("FAIL cont_gnt%0d: got %h expected %h", k, obs_gnt, 8'h01 << k);
            end
        end
        idle();
        checks++;
        if (obs_stall !== 32'd28 || obs_busy !== 32'd8) begin
            errors++; $display("FAIL cont_counters: got stall %0d busy %0d expected 28 8", obs_stall, obs_busy);
        end
        checks++;
        if (obs_rvalid !== 8'h80) begin errors++; $display("FAIL cont_rvalid: got %h expected 80", obs_rvalid); end
    endtask

    task automatic test_wrap();
        one(6, 1'b0, 32'h0, 32'h0);
        step(1'b0, 8'h81, '0, '0, '0);
        checks++;
        if (obs_gnt !== 8'h80) begin errors++; $display("FAIL wrap_gnt7: got %h expected 80", obs_gnt); end
        step(1'b0, 8'h01, '0, '0, '0);
        checks++;
        if (obs_gnt !== 8'h01) begin errors++; $display("FAIL wrap_gnt0: got %h expected 01", obs_gnt); end
        step(1'b0, 8'h03, '0, '0, '0);
        checks++;
        if (obs_gnt !== 8'h02) begin errors++; $display("FAIL wrap_ptr1: got %h expected 02", obs_gnt); end
        idle();
    endtask

    task automatic test_out_of_range();
        logic [31:0] w0;
        w0 = m_mem[0];
        one(3, 1'b1, 32'h400, 32'h12345678);
        one(3, 1'b0, 32'h400, 32'h0);
        idle();
        checks++;
        if (obs_rvalid !== 8'h08 || obs_rdata[3*32 +: 32] !== 32'h0) begin
            errors++; $display("FAIL oor_read: got rvalid %h rdata %h expected 08 00000000", obs_rvalid, obs_rdata[3*32 +: 32]);
        end
        one(0, 1'b0, 32'h0, 32'h0);
        idle();
        checks++;
        if (obs_rdata[31:0] !== w0) begin errors++; $display("FAIL oor_word0: got %h expected %h", obs_rdata[31:0], w0); end
    endtask

    task automatic test_cross_port();
        one(2, 1'b1, 32'h20, 32'hA5A5A5A5);
        one(5, 1'b0, 32'h20, 32'h0);
        idle();
        checks++;
        if (obs_rvalid !== 8'h20) begin errors++; $display("FAIL xp_rvalid: got %h expected 20", obs_rvalid); end
        checks++;
        if (obs_rdata[5*32 +: 32] !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL xp_rdata: got %h expected a5a5a5a5", obs_rdata[5*32 +: 32]);
        end
    endtask

    task automatic test_reset_mid();
        logic [NP*32-1:0] a;
        one(4, 1'b0, 32'h20, 32'h0);
        a = '0; a[31:0] = 32'h20;
        step(1'b1, 8'h01, 8'h01, a, {NP{32'h0BADF00D}});
        checks++;
        if (obs_rvalid !== 8'h00) begin errors++; $display("FAIL rm_rvalid: got %h expected 00", obs_rvalid); end
        step(1'b1, '0, '0, '0, '0);
        for (int i = 0; i < NP; i++) a[i*32 +: 32] = 32'h20;
        step(1'b0, 8'hFF, '0, a, '0);
        checks++;
        if (obs_gnt !== 8'h01) begin errors++; $display("FAIL rm_ptr: got %h expected 01", obs_gnt); end
        checks++;
        if (obs_busy !== 32'd0 || obs_stall !== 32'd0) begin
            errors++; $display("FAIL rm_counters: got busy %0d stall %0d expected 0 0", obs_busy, obs_stall);
        end
        idle();
        checks++;
        if (obs_rvalid !== 8'h01 || obs_rdata[31:0] !== 32'hA5A5A5A5 || obs_rdata[4*32 +: 32] !== 32'h0) begin
            errors++; $display("FAIL rm_preserve: got rvalid %h rdata0 %h rdata4 %h expected 01 a5a5a5a5 00000000",
                               obs_rvalid, obs_rdata[31:0], obs_rdata[4*32 +: 32]);
        end
        one(1, 1'b0, 32'h10, 32'h0);
        idle();
        checks++;
        if (obs_rdata[1*32 +: 32] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rm_preserve2: got %h expected deadbeef", obs_rdata[1*32 +: 32]);
        end
    endtask

    task automatic test_random();
        logic [NP*32-1:0] a, d;
        logic rst;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 7) == 0) a[i*32 +: 32] = $urandom | 32'h100;
                else a[i*32 +: 32] = 32'($urandom_range(0, 255));
                d[i*32 +: 32] = $urandom;
            end
            step(rst, NP'($urandom), NP'($urandom), a, d);
            checks++;
            if (obs_gnt !== exp_gnt) begin errors++; $display("FAIL rnd_gnt@%0d: got %h expected %h", n, obs_gnt, exp_gnt); end
            checks++;
            if (obs_rvalid !== exp_rvalid) begin
                errors++; $display("FAIL rnd_rvalid@%0d: got %h expected %h", n, obs_rvalid, exp_rvalid);
            end
            checks++;
            if (obs_rdata !== exp_rdata) begin
                errors++; $display("FAIL rnd_rdata@%0d: got %h expected %h", n, obs_rdata, exp_rdata);
            end
            checks++;
            if (obs_busy !== exp_busy || obs_stall !== exp_stall) begin
                errors++; $display("FAIL rnd_counters@%0d: got %0d/%0d expected %0d/%0d",
                                   n, obs_busy, obs_stall, exp_busy, exp_stall);
            end
        end
    endtask

    initial begin
        reset = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        m_ptr = 0; m_busy = '0; m_stall = '0; m_rdata = '0; m_rvalid = '0;
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
        test_reset();
        init_mem();
        test_single_write();
        test_contention();
        test_wrap();
        test_out_of_range();
        test_cross_port();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
